apb_regs_dut: RTL and testbench
===============================

APB_REGS_DUT -- requirements
Module: apb_regs_dut

Interface
REQ-001 Parameters (name, default, meaning):
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion (0..15).
- ID_VALUE, 32'hA9B0_0001, constant returned by the ID register.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low; clock and reset are PCLK and PRESETn.
REQ-003 All ports SHALL be carried on a single apb_if interface port named apb (name, direction, width, meaning):
- PCLK, in, 1, clock.
- PRESETn, in, 1, async active-low reset.
- PSEL, in, 1, slave select.
- PENABLE, in, 1, access phase.
- PWRITE, in, 1, 1 = write.
- PADDR, in, 32, byte address.
- PWDATA, in, 32, write data.
- PRDATA, out, 32, read data.
- PREADY, out, 1, transfer complete.
- PSLVERR, out, 1, transfer error.

Function
REQ-004 Register map:
- 0x00 ID: RO, returns ID_VALUE.
- 0x04 CTRL: RW, 32 bits.
- 0x08 STATUS: RO; [0] = |(INT_STAT & INT_EN); [15:1] = 0; [31:16] = ERR_CNT.
- 0x0C INT_EN: RW, bit 0 only; other bits read 0.
- 0x10 INT_STAT: W1C, bit 0.
- 0x14 SCRATCH: RW, 32 bits.
REQ-005 Decode error: PADDR > 0x14, PADDR[1:0] != 0, or a write to ID/STATUS.
REQ-006 Setup phase is PSEL=1, PENABLE=0. Access phase is PSEL=1, PENABLE=1. Completion is the PCLK edge with PSEL & PENABLE & PREADY.
REQ-007 PREADY:
- WAIT_STATES=0: PREADY SHALL be 1 in every cycle.
- Otherwise: PREADY SHALL be 0 for the first WAIT_STATES access-phase cycles and 1 after that.
- The wait counter SHALL clear at every setup phase.
REQ-008 PRDATA SHALL be combinational from PADDR whenever PSEL=1 and PWRITE=0. It SHALL be 0 for an errored address and 0 when PSEL=0.
REQ-009 Register writes SHALL take effect only at the completion edge, and only when the access is error-free; an errored write SHALL leave all registers unchanged.
REQ-010 At each setup-phase edge, an err register SHALL load the REQ-005 result. PSLVERR SHALL equal err.
REQ-011 err SHALL hold its value through completion and idle until the next setup phase, so PSLVERR remains readable after PSEL drops.
REQ-012 At an errored completion, INT_STAT[0] SHALL set and ERR_CNT SHALL increment, saturating at 0xFFFF.
REQ-013 Writing 1 to INT_STAT[0] SHALL clear it. If an error event and a W1C clear fall on the same edge, the set SHALL win.
REQ-014 Reads SHALL have no side effects.
REQ-015 Address bits above [7:0] SHALL participate in decode, so 0x100 is an error and does not alias 0x00.
REQ-016 If PSEL drops before completion, the transfer SHALL be abandoned with no register update; the err register SHALL keep its setup value.

Reset
REQ-017 While PRESETn=0, the following SHALL be 0: CTRL, INT_EN, INT_STAT, SCRATCH, ERR_CNT, err, and the wait counter.
REQ-018 During reset, PREADY SHALL be 1 when WAIT_STATES=0, and PSLVERR SHALL be 0.
REQ-019 Reset assertion mid-transfer SHALL abort the transfer with no write committed.

Structure
REQ-020 Package apb_regs_pkg SHALL hold the register offset constants, the ID default, the reset values and the field positions (STATUS pending bit, ERR_CNT range).
REQ-021 The block SHALL be a single module with no sub-modules; the decode logic and the wait counter are inline.

Verification
REQ-022 Reset, then read 0x00 -> PRDATA=0xA9B0_0001, PSLVERR=0.
REQ-023 Write 0x14=0xDEADBEEF, then read 0x14 -> 0xDEADBEEF, PSLVERR=0.
REQ-024 Read 0x100 -> PRDATA=0 and PSLVERR=1 at completion. PSLVERR SHALL still be 1 on the cycle after PSEL drops; STATUS[31:16]=1.
REQ-025 Write 0x08=0xFFFF_FFFF -> PSLVERR=1 and STATUS unchanged. Write 0x06 -> PSLVERR=1 and no register changes.
REQ-026 Sequence: write INT_EN=1, cause an error, read STATUS -> [0]=1. Then write INT_STAT=1 and read STATUS -> [0]=0.
REQ-027 With WAIT_STATES=2, write CTRL=0x5 -> PREADY low for 2 access cycles and completion on the third. A read of 0x04 then returns 0x5.

Source files
------------

// File: rtl/apb_regs_pkg.sv
// Register map, reset values and field positions shared by the APB register block.
package apb_regs_pkg;

  localparam logic [31:0] ID_OFF      = 32'h0000_0000;
  localparam logic [31:0] CTRL_OFF    = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFF  = 32'h0000_0008;
  localparam logic [31:0] INT_EN_OFF  = 32'h0000_000C;
  localparam logic [31:0] INT_STAT_OFF = 32'h0000_0010;
  localparam logic [31:0] SCRATCH_OFF = 32'h0000_0014;
  localparam logic [31:0] LAST_OFF    = SCRATCH_OFF;

  localparam logic [31:0] ID_DEFAULT  = 32'hA9B0_0001;

  localparam logic [31:0] CTRL_RST     = 32'h0000_0000;
  localparam logic [31:0] SCRATCH_RST  = 32'h0000_0000;
  localparam logic        INT_EN_RST   = 1'b0;
  localparam logic        INT_STAT_RST = 1'b0;
  localparam logic [15:0] ERR_CNT_RST  = 16'h0000;

  localparam int STATUS_PEND_BIT = 0;
  localparam int ERR_CNT_LSB     = 16;
  localparam int ERR_CNT_MSB     = 31;

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle with slave and master views.
interface apb_if;
  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport slave (
    input  PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

  modport master (
    input  PRDATA, PREADY, PSLVERR,
    output PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_regs_dut.sv
// APB register block: ID/CTRL/STATUS/INT_EN/INT_STAT/SCRATCH with decode-error
// reporting, error counting and an optional fixed number of wait states.
module apb_regs_dut
  import apb_regs_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  apb_if.slave apb
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] scratch_q, scratch_d;
  logic        int_en_q, int_en_d;
  logic        int_stat_q, int_stat_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_q, err_d;
  logic [3:0]  wait_q, wait_d;

  logic        setup, access, complete, dec_err;
  logic        wr_ok, err_evt, w1c_clr;
  logic [31:0] status_word, rdata;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign setup    = apb.PSEL & ~apb.PENABLE;
  assign access   = apb.PSEL &  apb.PENABLE;
  assign complete = access & apb.PREADY;

  // Full 32-bit compare so high address bits never alias onto the map.
  assign dec_err = (apb.PADDR > LAST_OFF) || (apb.PADDR[1:0] != 2'b00) ||
                   (apb.PWRITE && ((apb.PADDR == ID_OFF) || (apb.PADDR == STATUS_OFF)));

  assign wr_ok   = complete & ~err_q & apb.PWRITE;
  assign err_evt = complete &  err_q;
  assign w1c_clr = wr_ok & (apb.PADDR == INT_STAT_OFF) & apb.PWDATA[0];

  assign apb.PREADY  = (WS == 4'd0) ? 1'b1 : (wait_q == WS);
  assign apb.PSLVERR = err_q;

  always_comb begin
    status_word = '0;
    status_word[STATUS_PEND_BIT]         = int_stat_q & int_en_q;
    status_word[ERR_CNT_MSB:ERR_CNT_LSB] = err_cnt_q;
  end

  always_comb begin
    rdata = '0;
    if (apb.PSEL && !apb.PWRITE && !dec_err) begin
      unique case (apb.PADDR)
        ID_OFF:       rdata = ID_VALUE;
        CTRL_OFF:     rdata = ctrl_q;
        STATUS_OFF:   rdata = status_word;
        INT_EN_OFF:   rdata = {31'b0, int_en_q};
        INT_STAT_OFF: rdata = {31'b0, int_stat_q};
        SCRATCH_OFF:  rdata = scratch_q;
        default:      rdata = '0;
      endcase
    end
  end
  assign apb.PRDATA = rdata;

  always_comb begin
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    int_en_d   = int_en_q;
    err_cnt_d  = err_cnt_q;
    err_d      = err_q;
    wait_d     = wait_q;

    if (setup) begin
      wait_d = 4'd0;
      err_d  = dec_err;
    end else if (access && !apb.PREADY) begin
      wait_d = wait_q + 4'd1;
    end

    if (wr_ok) begin
      unique case (apb.PADDR)
        CTRL_OFF:    ctrl_d    = apb.PWDATA;
        INT_EN_OFF:  int_en_d  = apb.PWDATA[0];
        SCRATCH_OFF: scratch_d = apb.PWDATA;
        default:     ;
      endcase
    end

    if (err_evt) err_cnt_d = sat_inc16(err_cnt_q);
    // An error event on the same edge as a W1C clear leaves the bit set.
    int_stat_d = err_evt | (int_stat_q & ~w1c_clr);
  end

  always_ff @(posedge apb.PCLK or negedge apb.PRESETn) begin
    if (!apb.PRESETn) begin
      ctrl_q     <= CTRL_RST;
      scratch_q  <= SCRATCH_RST;
      int_en_q   <= INT_EN_RST;
      int_stat_q <= INT_STAT_RST;
      err_cnt_q  <= ERR_CNT_RST;
      err_q      <= 1'b0;
      wait_q     <= 4'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      scratch_q  <= scratch_d;
      int_en_q   <= int_en_d;
      int_stat_q <= int_stat_d;
      err_cnt_q  <= err_cnt_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_apb_regs_dut.sv
// Randomized and directed bench for apb_regs_dut: one instance with no wait
// states and one with two, both checked against a register-map model.
module tb_apb_regs_dut;
  import apb_regs_pkg::*;

  localparam logic [31:0] ID1 = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  int          tgt = 0;
  int          n_tests = 0, n_fail = 0;

  apb_if apb0 ();
  apb_if apb1 ();

  assign apb0.PCLK    = clk;
  assign apb0.PRESETn = rst_n;
  assign apb0.PSEL    = psel && (tgt == 0);
  assign apb0.PENABLE = penable;
  assign apb0.PWRITE  = pwrite;
  assign apb0.PADDR   = paddr;
  assign apb0.PWDATA  = pwdata;

  assign apb1.PCLK    = clk;
  assign apb1.PRESETn = rst_n;
  assign apb1.PSEL    = psel && (tgt == 1);
  assign apb1.PENABLE = penable;
  assign apb1.PWRITE  = pwrite;
  assign apb1.PADDR   = paddr;
  assign apb1.PWDATA  = pwdata;

  apb_regs_dut #(.WAIT_STATES(0)) u_dut0 (.apb(apb0));
  apb_regs_dut #(.WAIT_STATES(2), .ID_VALUE(ID1)) u_dut1 (.apb(apb1));

  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata;
  assign cur_pready  = (tgt == 1) ? apb1.PREADY  : apb0.PREADY;
  assign cur_pslverr = (tgt == 1) ? apb1.PSLVERR : apb0.PSLVERR;
  assign cur_prdata  = (tgt == 1) ? apb1.PRDATA  : apb0.PRDATA;

  always #5 clk = ~clk;

  // Reference model of the programmer-visible state of each instance.
  logic [31:0] m_id[2];
  logic [31:0] m_ctrl[2];
  logic [31:0] m_scratch[2];
  bit          m_inten[2];
  bit          m_intstat[2];
  int          m_errcnt[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int t);
    return (t == 1) ? 2 : 0;
  endfunction

  function automatic bit m_decerr(input bit wr, input logic [31:0] a);
    return (a > 32'h14) || (a % 4 != 0) || (wr && (a == 32'h0 || a == 32'h8));
  endfunction

  function automatic logic [31:0] m_read(input int t, input logic [31:0] a);
    if (a > 32'h14 || a % 4 != 0) return 32'h0;
    case (a)
      32'h00: return m_id[t];
      32'h04: return m_ctrl[t];
      32'h08: return (m_errcnt[t] << 16) | ((m_intstat[t] && m_inten[t]) ? 1 : 0);
      32'h0C: return m_inten[t] ? 32'h1 : 32'h0;
      32'h10: return m_intstat[t] ? 32'h1 : 32'h0;
      default: return m_scratch[t];
    endcase
  endfunction

  task automatic m_commit(input int t, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit e);
    if (e) begin
      m_intstat[t] = 1;
      if (m_errcnt[t] < 65535) m_errcnt[t]++;
    end else if (wr) begin
      case (a)
        32'h04: m_ctrl[t] = d;
        32'h0C: m_inten[t] = d[0];
        32'h10: if (d[0]) m_intstat[t] = 0;
        32'h14: m_scratch[t] = d;
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    for (int t = 0; t < 2; t++) begin
      m_ctrl[t] = 0; m_scratch[t] = 0; m_inten[t] = 0; m_intstat[t] = 0; m_errcnt[t] = 0;
    end
  endtask

  task automatic xfer(input int t, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err);
    int          waits;
    bit          done, exp_e;
    logic [31:0] exp_rd;
    exp_e  = m_decerr(wr, a);
    exp_rd = m_read(t, a);
    rd = '0; err = 1'b0;
    @(negedge clk);
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    waits = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (cur_pready === 1'b1) begin
        rd = cur_prdata; err = cur_pslverr; done = 1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!done) chk("pready_timeout", 32'(done), 32'h1);
    chk("wait_states", waits, ws_of(t));
    chk("pslverr", err, exp_e);
    if (!wr) chk("prdata", rd, exp_rd);
    @(posedge clk);
    m_commit(t, wr, a, d, exp_e);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] alist[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_id[0] = ID_DEFAULT;
    m_id[1] = ID1;
    m_reset();
    alist = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h100, 32'h6, 32'h2};

    repeat (2) @(negedge clk);
    chk("rst_pready_ws0", apb0.PREADY, 1'b1);
    chk("rst_pslverr0", apb0.PSLVERR, 1'b0);
    chk("rst_pslverr1", apb1.PSLVERR, 1'b0);
    rst_n = 1'b1;

    // Reset state of every readable register on both instances.
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 6; i++) xfer(t, 0, alist[i], 0, rd, er);

    xfer(0, 0, 32'h0, 0, rd, er);
    chk("id_read", rd, 32'hA9B0_0001);
    xfer(0, 1, 32'h14, 32'hDEADBEEF, rd, er);
    xfer(0, 0, 32'h14, 0, rd, er);
    chk("scratch_read", rd, 32'hDEADBEEF);

    xfer(0, 0, 32'h100, 0, rd, er);
    chk("err_rdata", rd, 32'h0);
    @(negedge clk);
    chk("pslverr_hold", apb0.PSLVERR, 1'b1);
    xfer(0, 0, 32'h8, 0, rd, er);
    chk("errcnt_1", rd[31:16], 32'h1);

    xfer(0, 1, 32'h8, 32'hFFFF_FFFF, rd, er);
    xfer(0, 0, 32'h8, 0, rd, er);
    xfer(0, 1, 32'h6, 32'h1234_5678, rd, er);
    for (int i = 0; i < 6; i++) xfer(0, 0, alist[i], 0, rd, er);

    xfer(0, 1, 32'hC, 32'h1, rd, er);
    xfer(0, 0, 32'h200, 0, rd, er);
    xfer(0, 0, 32'h8, 0, rd, er);
    chk("pend_set", rd[0], 1'b1);
    xfer(0, 1, 32'h10, 32'h1, rd, er);
    xfer(0, 0, 32'h8, 0, rd, er);
    chk("pend_clr", rd[0], 1'b0);

    xfer(1, 1, 32'h4, 32'h5, rd, er);
    xfer(1, 0, 32'h4, 0, rd, er);
    chk("ctrl_ws2", rd, 32'h5);

    for (int n = 0; n < 300; n++) begin
      int   t, k;
      bit   wr;
      logic [31:0] a;
      t  = int'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 10));
      wr = 1'($urandom_range(0, 1));
      a  = (k == 10) ? ($urandom & 32'h1FF) : alist[k];
      xfer(t, wr, a, $urandom, rd, er);
    end
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 6; i++) xfer(t, 0, alist[i], 0, rd, er);

    // Reset arriving while a write is stalled in wait states.
    xfer(1, 1, 32'h14, 32'h1111_2222, rd, er);
    @(negedge clk);
    tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hCAFE_F00D;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    chk("rst_mid_pslverr", apb1.PSLVERR, 1'b0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 6; i++) xfer(t, 0, alist[i], 0, rd, er);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
